// File: rtl/ahbl_sram_waitstate.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ahbl_sram_waitstate                                          |
// | Description : AHB-Lite SRAM slave model with fixed wait states, external   |
// |               stall input and optional two-cycle ERROR responses enabled   |
// |               by the AHBL_SRAM_ERR_EN macro.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ahbl_sram_waitstate #(
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 0,
  parameter int W_ADDR      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_ADDR-1:0] haddr,
  input  logic              hwrite,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic              hready,
  output logic              hready_resp,
  output logic              hresp,
  input  logic [31:0]       hwdata,
  output logic [31:0]       hrdata,
  input  logic              stall_req
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] c_wait_init = 4'(WAIT_CYCLES);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WAIT = 2'd1;
`ifdef AHBL_SRAM_ERR_EN
  localparam logic [1:0] c_ST_ERR1 = 2'd2;
  localparam logic [1:0] c_ST_ERR2 = 2'd3;
`endif

  logic [1:0]    r_state;
  logic [3:0]    r_wcount;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_lane;
  logic [2:0]    r_size;
  logic          r_write;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_done;
  logic          w_free;
  logic          w_hready;
  logic [3:0]    w_be;
  logic [AW-1:0] w_idx;
  logic          w_unused;

  assign w_accept = hready && htrans[1];
  assign w_idx    = haddr[2 +: AW];
  assign w_done   = (r_state == c_ST_WAIT) && (r_wcount == 4'd0) && !stall_req;
  assign w_unused = &{1'b0, htrans[0], haddr};

`ifdef AHBL_SRAM_ERR_EN
  logic w_err;
  // Index range check relies on DEPTH being a power of two.
  assign w_err = (hsize > 3'd2)
              || ((hsize == 3'd1) && haddr[0])
              || ((hsize == 3'd2) && (haddr[1:0] != 2'b00))
              || (|(haddr >> (AW + 2)));
  assign w_free = (r_state == c_ST_IDLE) || w_done || (r_state == c_ST_ERR2);
  assign hresp  = (r_state == c_ST_ERR1) || (r_state == c_ST_ERR2);
`else
  assign w_free = (r_state == c_ST_IDLE) || w_done;
  assign hresp  = 1'b0;
`endif

  always_comb begin
    w_hready = 1'b1;
    case (r_state)
      c_ST_WAIT: w_hready = w_done;
`ifdef AHBL_SRAM_ERR_EN
      c_ST_ERR1: w_hready = 1'b0;
`endif
      default:   w_hready = 1'b1;
    endcase
  end

  assign hready_resp = w_hready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_ST_IDLE;
      r_wcount <= 4'd0;
      r_idx    <= '0;
      r_lane   <= 2'b00;
      r_size   <= 3'd0;
      r_write  <= 1'b0;
    end else if (w_free) begin
      if (w_accept) begin
        r_idx   <= w_idx;
        r_lane  <= haddr[1:0];
        r_size  <= hsize;
        r_write <= hwrite;
`ifdef AHBL_SRAM_ERR_EN
        if (w_err) begin
          r_state <= c_ST_ERR1;
        end else begin
          r_state  <= c_ST_WAIT;
          r_wcount <= c_wait_init;
        end
`else
        r_state  <= c_ST_WAIT;
        r_wcount <= c_wait_init;
`endif
      end else begin
        r_state <= c_ST_IDLE;
      end
    end else if (r_state == c_ST_WAIT) begin
      if (r_wcount != 4'd0) begin
        r_wcount <= r_wcount - 4'd1;
      end
`ifdef AHBL_SRAM_ERR_EN
    end else if (r_state == c_ST_ERR1) begin
      r_state <= c_ST_ERR2;
`endif
    end
  end

  // Sizes above word only reach here with errors disabled; they act as word.
  always_comb begin
    case (r_size)
      3'd0:    w_be = 4'b0001 << r_lane;
      3'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_done && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
        end
      end
    end
  end

  assign hrdata = ((r_state == c_ST_WAIT) && !r_write) ? r_mem[r_idx] : 32'd0;

endmodule
`default_nettype wire

// File: doc/ahbl_sram_waitstate.md
# ahbl_sram_waitstate

AHB-Lite slave memory model for simulation and formal benches around `hazard3_cpu_2port`. One instance sits directly downstream of each CPU bus port (I and D) and produces the `hready`/`hresp`/`hrdata` that the core consumes. It adds a fixed wait-state count plus an external stall input, so benches can exercise bus stalls deterministically or randomly. It also has optional error responses, with behaviour that stays legal under the AHB-Lite slave assumptions the benches already apply.

## Interface
Parameters:
- `DEPTH`, 4096: memory size in 32-bit words; power of two.
- `WAIT_CYCLES`, 0: fixed wait states inserted into every OKAY data phase; 0..15.
- `W_ADDR`, 32: bus address width.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `haddr` input W_ADDR: address-phase address.
- `hwrite` input 1: address-phase write flag.
- `htrans` input 2: transfer type; bit 1 set = NONSEQ/SEQ.
- `hsize` input 3: transfer size.
- `hready` input 1: bus-level ready; in point-to-point benches, tie it to `hready_resp`.
- `hready_resp` output 1: slave ready.
- `hresp` output 1: 1 = ERROR.
- `hwdata` input 32: write data, data phase.
- `hrdata` output 32: read data, data phase.
- `stall_req` input 1: when high, forces `hready_resp` low in a pending OKAY data phase.

## Operation
- Address phase accepted when `hready && htrans[1]`. On accept, register `haddr`, `hwrite`, `hsize` and the error decision.
- States:
  - IDLE: no active data phase.
  - WAIT: active data phase, counter or stall pending.
  - ERR1: first error cycle.
  - ERR2: second error cycle.
- Transitions:
  - Accept with error goes to ERR1, then ERR2. ERR2 goes to the next state per the address phase sampled in ERR2.
  - Accept without error loads `wcount = WAIT_CYCLES` and enters WAIT.
  - WAIT completes when `wcount == 0 && !stall_req`. Otherwise, `wcount` decrements, saturating at 0, every cycle.
  - Completion with no new accept goes to IDLE. Completion with a new accept reloads back-to-back.
- Error decision (macro only):
  - `hsize > 2`.
  - Halfword with `haddr[0]`.
  - Word with `haddr[1:0] != 0`.
  - Word index `>= DEPTH`.
- Writes: commit on the completing edge of the data phase. Byte enables come from the registered `hsize` and `haddr[1:0]`, little-endian. Byte lanes are taken from the matching `hwdata` lanes.
- Reads: `hrdata` = full 32-bit word at the registered index, all lanes, driven during a read data phase. Otherwise `hrdata` = 0.
- Memory is not reset; simulation initial contents are 0.
- Address index is `haddr[2 +: log2(DEPTH)]`. Without the macro, upper bits are ignored, so accesses wrap modulo DEPTH.

## Timing
- Reset values: `hready_resp`=1, `hresp`=0, `hrdata`=0, state IDLE, `wcount`=0.
- Reset mid-transfer aborts the data phase. A write in flight is not committed.
- OKAY latency: a data phase lasts `1 + WAIT_CYCLES + N` cycles, where N = cycles with `stall_req` high once `wcount` reaches 0.
- `stall_req` is sampled combinationally into `hready_resp` during WAIT only. It is ignored in IDLE, ERR1 and ERR2, so `hready_resp`=1 in IDLE.
- ERROR: two cycles.
  - ERR1: `hready_resp`=0, `hresp`=1.
  - ERR2: `hready_resp`=1, `hresp`=1.
  - A write that errors is never committed.
- Read-after-write, same address, back-to-back: the read data phase returns the new data. The write commits on the edge that starts the read's data phase.
- An IDLE or BUSY `htrans` during a data phase produces no new data phase.

## Configuration
- `AHBL_SRAM_ERR_EN` defined: error decision, ERR1 and ERR2 are present.
- Undefined: `hresp` is constant 0 and ERR states are absent. Misaligned and oversize accesses execute with the enables derived from the low address bits; `hsize > 2` is treated as word. Out-of-range addresses wrap.

## Test plan
- Reset with `WAIT_CYCLES=0`, then write 0xDEADBEEF to word 0x10, then read 0x10 back-to-back -> `hready_resp` constantly 1; `hrdata`=0xDEADBEEF in the read data phase.
- `WAIT_CYCLES=3`, single read -> `hready_resp` low for exactly 3 cycles, then high with data.
- `WAIT_CYCLES=0`, `stall_req` high for 5 cycles during a write -> `hready_resp` low for 5 cycles; memory unchanged until the completing edge.
- Byte write 0xAA to address 0x41 over word 0x11223344 -> subsequent word read returns 0x1122AA44.
- Macro on: halfword read at 0x3 -> ERR1 (`hready_resp`=0, `hresp`=1), then ERR2 (1,1), then IDLE. Word write out of range -> memory unchanged.
- `rst_n` asserted mid-WAIT of a write -> outputs return to reset values immediately; after release, a read of that address shows the old data.
